// File: rtl/wb_dual_commit_pkg.sv
// Shared widths, bus layouts and helpers for the WB stage. The optional trace FIFO is
// enabled with the WB_TRACE_FIFO_EN macro.
package wb_dual_commit_pkg;

  localparam int unsigned STALLBUS_WD    = 6;
  localparam int unsigned STALL_MEM_BIT  = 5;
  localparam logic        STOP           = 1'b1;

  localparam int unsigned MEM_INST_INFO  = 136;
  localparam int unsigned MEM_TO_WB_WD   = 2 * MEM_INST_INFO;
  localparam int unsigned WB_TO_RF_WD    = 76;
  localparam int unsigned TRACE_ENTRY_WD = 70;

  // hilo_bus field offsets within the 66-bit hilo field
  localparam int unsigned HILO_HI_WE = 65;
  localparam int unsigned HILO_LO_WE = 64;
  localparam int unsigned HILO_HI_LSB = 32;
  localparam int unsigned HILO_LO_LSB = 0;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_bus_t;

  typedef struct packed {
    hilo_bus_t   hilo;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_inst_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_entry_t;

  function automatic trace_entry_t to_trace(input mem_inst_t s);
    trace_entry_t e;
    e.pc    = s.pc;
    e.we    = s.rf_we;
    e.waddr = s.rf_waddr;
    e.wdata = s.rf_wdata;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Two-push / one-pop retirement trace FIFO. Pops one entry per cycle whenever non-empty;
// the head reads as zero while empty.
module wb_trace_fifo
  import wb_dual_commit_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(TRACE_DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push1_i,
  input  trace_entry_t entry1_i,
  input  logic         push2_i,
  input  trace_entry_t entry2_i,
  output trace_entry_t head_o,
  output logic [PTR_W:0] count_o
);

  localparam int unsigned CntW = PTR_W + 2;

  trace_entry_t     mem_q [TRACE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nxt;
  logic [PTR_W:0]   count_q, count_d;
  logic [CntW-1:0]  cnt_sum;
  logic             pop;

  assign pop        = (count_q != '0);
  assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

  always_comb begin
    cnt_sum  = CntW'(count_q) + CntW'(push1_i) + CntW'(push2_i) - CntW'(pop);
    count_d  = cnt_sum[PTR_W:0];
    wr_ptr_d = wr_ptr_q + PTR_W'(push1_i) + PTR_W'(push2_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // Slot1 is older, so it takes the lower slot when both push together
  always_ff @(posedge clk_i) begin
    if (push1_i) mem_q[wr_ptr_q] <= entry1_i;
    if (push2_i) mem_q[push1_i ? wr_ptr_nxt : wr_ptr_q] <= entry2_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (cnt_sum <= CntW'(TRACE_DEPTH)) else $error("trace fifo overflow");
  end

  assign head_o  = pop ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/wb_dual_commit.sv
// Dual-issue writeback: regfile commit for both slots, architectural HI/LO, and the debug
// retirement trace (FIFO-serialised when WB_TRACE_FIFO_EN is defined, slot1-only otherwise).
module wb_dual_commit
  import wb_dual_commit_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALLBUS_WD-1:0]  stall,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o,
  output logic                    stallreq_trace,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  if (TRACE_DEPTH < 4 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TRACE_DEPTH must be a power of two >= 4");
  end

  logic [MEM_TO_WB_WD-1:0] wb_q, wb_d;
  mem_inst_t               slot1, slot2;
  logic                    slot1_vld;
  logic                    we1, we2;
  logic [31:0]             hi_q, hi_d, lo_q, lo_d;
  logic                    unused_stall;

  assign unused_stall = ^stall[STALL_MEM_BIT-1:0];

  // No flush: MEM has already squashed, so only a held MEM stage injects a bubble
  assign wb_d = (stall[STALL_MEM_BIT] == STOP) ? '0 : mem_to_wb_bus;

  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign slot1     = wb_q[MEM_INST_INFO-1:0];
  assign slot2     = wb_q[MEM_TO_WB_WD-1:MEM_INST_INFO];
  assign slot1_vld = (slot1.pc != '0);

  // Slot2 is younger, so it owns a shared destination
  assign we1 = slot1.rf_we && (slot1.rf_waddr != '0) &&
               !(slot2.rf_we && (slot1.rf_waddr == slot2.rf_waddr));
  assign we2 = slot2.rf_we && (slot2.rf_waddr != '0);

  assign wb_to_rf_bus = {we2, slot2.rf_waddr, slot2.rf_wdata,
                         we1, slot1.rf_waddr, slot1.rf_wdata};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (slot1.hilo.hi_we) hi_d = slot1.hilo.hi;
    if (slot1.hilo.lo_we) lo_d = slot1.hilo.lo;
    if (slot2.hilo.hi_we) hi_d = slot2.hilo.hi;
    if (slot2.hilo.lo_we) lo_d = slot2.hilo.lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

`ifdef WB_TRACE_FIFO_EN
  localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);

  trace_entry_t   entry1, entry2, head;
  logic           slot2_vld;
  logic [PTR_W:0] trace_cnt;

  assign slot2_vld = (slot2.pc != '0);
  assign entry1    = to_trace(slot1);
  assign entry2    = to_trace(slot2);

  wb_trace_fifo #(
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push1_i (slot1_vld),
    .entry1_i(entry1),
    .push2_i (slot2_vld),
    .entry2_i(entry2),
    .head_o  (head),
    .count_o (trace_cnt)
  );

  // Leaves room for the pair already sitting in the WB register
  assign stallreq_trace    = (32'(trace_cnt) >= TRACE_DEPTH - 32'd2);
  assign debug_wb_pc       = head.pc;
  assign debug_wb_rf_wen   = {4{head.we}};
  assign debug_wb_rf_wnum  = head.waddr;
  assign debug_wb_rf_wdata = head.wdata;
`else
  logic unused_slot2_pc;

  assign unused_slot2_pc   = ^slot2.pc;
  assign stallreq_trace    = 1'b0;
  assign debug_wb_pc       = slot1_vld ? slot1.pc : '0;
  assign debug_wb_rf_wen   = {4{slot1_vld & slot1.rf_we}};
  assign debug_wb_rf_wnum  = slot1_vld ? slot1.rf_waddr : '0;
  assign debug_wb_rf_wdata = slot1_vld ? slot1.rf_wdata : '0;
`endif

endmodule

// File: doc/wb_dual_commit.md
Name: wb_dual_commit

Overview:
- Final (WB) stage of the dual-issue MIPS pipeline. Consumes the 2-slot MEM→WB bus.
- Commits regfile writes for both slots, with slot2 taking program-order precedence.
- Owns the architectural HI/LO registers.
- Serialises up to two retirements per cycle into a one-per-cycle debug trace through a small FIFO, with back-pressure into the stall controller.

Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two, ≥4.
- PTR_W, $clog2(TRACE_DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  `STALLBUS_WD  pipeline stall bus; bit 5 = MEM stage held
- mem_to_wb_bus  in  `MEM_TO_WB_WD (272)  {slot2[135:0], slot1[135:0]}; each slot = {hilo_bus[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}; hilo_bus = {hi_we, lo_we, hi[31:0], lo[31:0]}; invalid slot = all zero
- wb_to_rf_bus  out  76  {we2, waddr2[4:0], wdata2[31:0], we1, waddr1[4:0], wdata1[31:0]}
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- stallreq_trace  out  1  trace FIFO back-pressure to ctrl
- debug_wb_pc  out  32  retired PC, one per cycle
- debug_wb_rf_wen  out  4  byte write enables (all-or-nothing)
- debug_wb_rf_wnum  out  5  destination register
- debug_wb_rf_wdata  out  32  write data

Behaviour:
- WB register (272 b), loaded each posedge:
  - rst: load 0.
  - stall[5]==`Stop: load 0 (bubble).
  - Otherwise: load mem_to_wb_bus.
  - No flush input. MEM already squashes, and a kept slot1 must still commit.
- Slot valid = slot pc != 0.
- Regfile commit (combinational from WB register):
  - we1 is forced 0 when rf_we2 && rf_we1 && waddr1==waddr2.
  - Either we forced 0 when its waddr==0.
  - Data and addresses pass through unchanged.
- HI/LO registers:
  - Reset to 0.
  - Each posedge, apply slot1 hi_we/lo_we, then slot2. Slot2 wins on a same-register conflict.
  - hi_o/lo_o are the register outputs. New value is visible the cycle after commit; EX forwards the in-flight value from mem_to_rf.
- Trace FIFO entry: {pc, we, waddr, wdata} (70 b).
  - Per posedge push: slot1 then slot2, valid slots only (0/1/2 pushes). Pop 1 if count>0. Pushes and pop are simultaneous.
  - count_next = count + pushes − pop.
  - Pointers wrap modulo TRACE_DEPTH.
- Debug outputs (combinational from FIFO head):
  - debug_wb_pc = head.pc.
  - debug_wb_rf_wen = {4{head.we}}. A store or branch still shows its PC with wen=0.
  - Raw we is reported, including waddr==0.
  - When empty, all debug outputs are 0.
  - Latency: a slot in the WB register appears on debug no earlier than the next cycle. Program order is strictly preserved.
- stallreq_trace = (count >= TRACE_DEPTH−2), using the registered count.
  - Guarantees no overflow: the one in-flight pair still fits, since worst case is count TRACE_DEPTH−2 +2 −1.
  - Overflow is an assertion failure in sim.
- Reset mid-operation:
  - FIFO pointers and count clear. Pending trace entries are discarded.
  - WB register and HI/LO clear.
  - Debug outputs are 0 next cycle.

Optional Feature:
- Macro WB_TRACE_FIFO_EN.
- Defined: trace FIFO as above.
- Undefined:
  - No FIFO storage.
  - debug_* driven combinationally from WB slot1 only. Slot2 retirements are not traced; this mode is for synthesis/area builds.
  - stallreq_trace tied 0.

Decomposition:
- Add to lib/defines.vh:
  - `WB_TO_RF_WD (76)
  - `TRACE_ENTRY_WD (70)
  - `MEM_INST_INFO (136)
  - hilo_bus field offsets
- One sub-module, wb_trace_fifo: 2-in/1-out FIFO with count output, parameterised on TRACE_DEPTH.

Test Plan:
- Same-destination dual write: slot1 {pc=0xBFC00000, we=1, waddr=8, wdata=1}, slot2 {pc=0xBFC00004, we=1, waddr=8, wdata=2} → wb_to_rf we1=0, we2=1. Next two cycles debug shows pc 0xBFC00000/wdata 1, then 0xBFC00004/wdata 2.
- HI/LO conflict: slot1 hilo {1,1,0x11,0x22}, slot2 {1,0,0x33,0x44} → next cycle hi_o=0x33, lo_o=0x22.
- Back-pressure: 4 consecutive dual-valid cycles, DEPTH=4 → stallreq_trace rises when count=2. Bench applies stall[5]; no overflow assertion fires. Trace drains 8 PCs in order, then stallreq drops at count<2.
- Bubble/invalid: stall[5]=Stop for 3 cycles → WB register zero, no rf writes, no pushes, debug 0 once drained.
- $0 write: slot1 we=1, waddr=0, wdata=0xFFFF → wb_to_rf we1=0. Trace shows wen=4'hF, wnum=0.
- Reset mid-drain: rst with count=3 → next cycle debug_wb_pc=0, stallreq_trace=0, hi_o=lo_o=0.
